shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit barrel shifter among NUM_REQ requesters. It accepts one shift command at a time through a valid/ready handshake and registers the command operands into the shifter's inputs. It captures the shifter result and returns it with the requester ID through a backpressured response port. It sits between the datapath's shift-issuing units and the single shifter instance.

---
 rtl/shift_arbiter.sv | 178 +++++++++++++++++
 tb/tb_shift_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one 16-bit barrel shifter among NUM_REQ requesters.
// Optional illegal-code flagging is enabled by defining SHIFT_ARB_ILLEGAL_CHECK_EN.
module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_select,
  input  logic [4*NUM_REQ-1:0]  req_amount,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]      op_sel_q, op_sel_d;
  logic [3:0]      op_amt_q, op_amt_d;
  logic [15:0]     op_data_q, op_data_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [15:0]     shift_result;

  function automatic logic [15:0] barrel_shift(input logic [2:0]  sel,
                                               input logic [3:0]  amt,
                                               input logic [15:0] d);
    logic [31:0] dbl;
    logic [15:0] res;
    dbl = {d, d};
    res = 16'h0000;
    case (sel)
      3'b000: res = d >> amt;
      3'b001: res = d << amt;
      3'b010: begin
        dbl = dbl >> amt;
        res = dbl[15:0];
      end
      3'b011: begin
        dbl = dbl << amt;
        res = dbl[31:16];
      end
      3'b110: res = $signed(d) >>> amt;
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  // Circular search: scanning from the far end lets the index nearest rr_ptr win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign shift_result = barrel_shift(op_sel_q, op_amt_q, op_data_q);

`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
  logic op_err_q, op_err_d;
  logic rsp_err_q, rsp_err_d;
  logic grant_illegal;

  assign grant_illegal = (req_select[3*int'(grant_idx) +: 3] == 3'b100) ||
                         (req_select[3*int'(grant_idx) +: 3] == 3'b101) ||
                         (req_select[3*int'(grant_idx) +: 3] == 3'b111);
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_sel_d   = op_sel_q;
    op_amt_d   = op_amt_q;
    op_data_d  = op_data_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
    op_err_d   = op_err_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_sel_d  = req_select[3*int'(grant_idx) +: 3];
          op_amt_d  = req_amount[4*int'(grant_idx) +: 4];
          op_data_d = req_data[16*int'(grant_idx) +: 16];
          op_id_d   = grant_idx;
          rr_ptr_d  = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
          op_err_d  = grant_illegal;
`endif
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = shift_result;
        rsp_id_d   = op_id_q;
`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
        rsp_err_d  = op_err_q;
        if (op_err_q) begin
          rsp_data_d = 16'h0000;
        end
`endif
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_sel_q   <= '0;
      op_amt_q   <= '0;
      op_data_q  <= '0;
      op_id_q    <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
      op_err_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_sel_q   <= op_sel_d;
      op_amt_q   <= op_amt_d;
      op_data_q  <= op_data_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
      op_err_q   <= op_err_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (NUM_REQ=4) with hand-computed results.
module tb_shift_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_select;
  logic [4*NUM_REQ-1:0]  req_amount;
  logic [16*NUM_REQ-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_data;
  logic                  rsp_err;

  int errors = 0;
  int checks = 0;
  logic exp_illegal_err;

  shift_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_select(req_select),
    .req_amount(req_amount),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [2:0] sel, input logic [3:0] amt,
                               input logic [15:0] data);
    req_select[3*id +: 3]  = sel;
    req_amount[4*id +: 4]  = amt;
    req_data[16*id +: 16]  = data;
    req_valid[id]          = 1'b1;
  endtask

  // Called at posedge+1 with the DUT idle and rsp_ready high; returns at posedge+1, idle again.
  task automatic runCommand(input string tag, input int id, input logic [2:0] sel,
                            input logic [3:0] amt, input logic [15:0] data,
                            input logic [15:0] exp_data, input logic exp_err,
                            input logic [ID_W-1:0] exp_ptr);
    applyStimulus(id, sel, amt, data);
    #1;
    checkOutput({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    checkOutput({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_ptr"}, 32'(dut.rr_ptr_q), 32'(exp_ptr));
    @(posedge clk); #1;
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    checkOutput({tag, "_retired"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int exp_g[4];
    int exp_p[4];
    int n;
    int cyc;
    int last;
    int g;

`ifdef SHIFT_ARB_ILLEGAL_CHECK_EN
    exp_illegal_err = 1'b1;
`else
    exp_illegal_err = 1'b0;
`endif
    rst        = 1'b1;
    req_valid  = '0;
    req_select = '0;
    req_amount = '0;
    req_data   = '0;
    rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_ptr", 32'(dut.rr_ptr_q), 32'd0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single commands across shift codes");
    runCommand("lsr",   1, 3'b000, 4'd4,  16'h8F00, 16'h08F0, 1'b0, 2'd2);
    runCommand("asr",   2, 3'b110, 4'd4,  16'h8F00, 16'hF8F0, 1'b0, 2'd3);
    runCommand("lsl",   3, 3'b001, 4'd15, 16'h0003, 16'h8000, 1'b0, 2'd0);
    runCommand("ror",   0, 3'b010, 4'd4,  16'h1234, 16'h4123, 1'b0, 2'd1);
    runCommand("rol",   1, 3'b011, 4'd4,  16'h1234, 16'h2341, 1'b0, 2'd2);
    runCommand("ror0",  2, 3'b010, 4'd0,  16'hABCD, 16'hABCD, 1'b0, 2'd3);
    runCommand("illeg", 3, 3'b101, 4'd3,  16'h1234, 16'h0000, exp_illegal_err, 2'd0);

    $display("[TB] round robin over requesters 0, 2, 3");
    exp_g = '{0, 2, 3, 0};
    exp_p = '{1, 3, 0, 1};
    applyStimulus(0, 3'b000, 4'd0, 16'h0011);
    applyStimulus(2, 3'b000, 4'd0, 16'h0022);
    applyStimulus(3, 3'b000, 4'd0, 16'h0033);
    n    = 0;
    cyc  = 0;
    last = 0;
    #1;
    while (n < 4 && cyc < 30) begin
      if (req_ready != '0) begin
        g = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (req_ready[i]) g = i;
        end
        checkOutput("rr_onehot", 32'($countones(req_ready)), 32'd1);
        checkOutput("rr_grant", 32'(g), 32'(exp_g[n]));
        if (n > 0) checkOutput("rr_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        @(posedge clk); #1;
        checkOutput("rr_ptr", 32'(dut.rr_ptr_q), 32'(exp_p[n]));
        n++;
        if (n == 4) req_valid = '0;
        #1;
        cyc++;
      end else begin
        @(posedge clk); #2;
        cyc++;
      end
    end
    if (n < 4) checkOutput("rr_budget", 32'(n), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rr_drained", 32'(rsp_valid), 32'd0);

    $display("[TB] backpressure on the response port");
    rsp_ready = 1'b0;
    applyStimulus(1, 3'b000, 4'd1, 16'h0100);
    applyStimulus(2, 3'b011, 4'd1, 16'h8001);
    #1;
    checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_hold_data", 32'(rsp_data), 32'h0080);
      checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #2;
    checkOutput("bp_next_grant", 32'(req_ready), 32'b0100);
    checkOutput("bp_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_rsp2_id", 32'(rsp_id), 32'd2);
    checkOutput("bp_rsp2_data", 32'(rsp_data), 32'h0003);
    @(posedge clk); #1;

    $display("[TB] reset during execution");
    applyStimulus(1, 3'b000, 4'd0, 16'h5555);
    #1;
    checkOutput("rst_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("[TB] reset dominates a coincident request");
    rst = 1'b1;
    applyStimulus(0, 3'b110, 4'd15, 16'h8000);
    applyStimulus(2, 3'b000, 4'd1, 16'h0002);
    #1;
    checkOutput("rstdom_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rstdom_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    checkOutput("rstdom_ptr", 32'(dut.rr_ptr_q), 32'd1);
    @(posedge clk); #1;
    checkOutput("rstdom_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rstdom_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rstdom_rsp_data", 32'(rsp_data), 32'hFFFF);
    @(posedge clk); #1;
    checkOutput("rstdom_retired", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
